// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester at a time owns the shared sink for a
// whole burst of 1..MAX_BURST beats, and the winner's beats are passed straight through.
module rr_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int LEN_WIDTH = $clog2(MAX_BURST + 1),
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [ID_WIDTH-1:0]             out_id,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int IW1 = ID_WIDTH + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [LEN_WIDTH-1:0]  r_remaining;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_sel;
  logic [IW1-1:0]        w_idx;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic [LEN_WIDTH-1:0]  w_eff_len;
  logic                  w_transfer;

  // Search upward from the pointer; the index is kept one bit wider so the wrap
  // works for any NUM_REQ, not only powers of two.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW1'(k);
      if (w_idx >= IW1'(NUM_REQ)) w_idx = w_idx - IW1'(NUM_REQ);
      if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  assign w_sel_len = req_len[w_sel*LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    if (w_sel_len == '0)
      w_eff_len = LEN_WIDTH'(1);
    else if (w_sel_len > LEN_WIDTH'(MAX_BURST))
      w_eff_len = LEN_WIDTH'(MAX_BURST);
    else
      w_eff_len = w_sel_len;
  end

  // Handshake: a beat moves on any cycle where out_valid and out_ready are both
  // high; req_ready of the granted requester simply mirrors out_ready.
  assign w_transfer = (r_state == S_BURST) && req_valid[r_grant] && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_sel;
            r_remaining <= w_eff_len;
            r_ptr       <= (w_sel == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_transfer) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_WIDTH'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_id = r_grant;

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (r_state == S_BURST) begin
      out_valid          = req_valid[r_grant];
      out_data           = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
      out_last           = (r_remaining == LEN_WIDTH'(1));
      req_ready[r_grant] = out_ready;
      busy               = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: a queue/arithmetic model checked every cycle, plus a
// burst scoreboard fed with hand-computed grant order, burst lengths and beat data.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int LW = 4;
  localparam int IW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance (4 requesters, bursts up to 8)
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid, out_last, out_ready, busy;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  rr_burst_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_len(req_len), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  // second instance: 3 requesters, single-beat bursts
  logic [2:0]    b_req_valid;
  logic [2:0]    b_req_len;
  logic [23:0]   b_req_data;
  logic [2:0]    b_req_ready;
  logic          b_out_valid, b_out_last, b_out_ready, b_busy;
  logic [7:0]    b_out_data;
  logic [1:0]    b_out_id;

  rr_burst_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_len(b_req_len), .req_data(b_req_data), .req_ready(b_req_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last), .out_id(b_out_id),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // behavioural model: owner of the sink, beats still owed, next search start
  int m_busy, m_ptr, m_grant, m_rem, m_pick;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MB) return MB;
    return l;
  endfunction

  function automatic int len_of(input int i);
    return int'(req_len[i*LW +: LW]);
  endfunction

  always_comb m_pick = pick(req_valid, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_ptr <= 0; m_grant <= 0; m_rem <= 0;
    end else if (m_busy == 0) begin
      if (m_pick >= 0) begin
        m_busy  <= 1;
        m_grant <= m_pick;
        m_rem   <= eff_len(len_of(m_pick));
        m_ptr   <= (m_pick + 1) % N;
      end
    end else if (req_valid[m_grant] && out_ready) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_busy <= 0;
    end
  end

  // scoreboard
  logic [15:0] exp_q[$];
  logic [7:0]  dat_q[$];
  logic [1:0]  b_exp_q[$];
  int beat_cnt = 0, beats_total = 0, bursts_done = 0;
  logic dat_on = 1'b0;
  logic [N-1:0]  e_ready;
  logic [DW-1:0] e_data;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_cnt = 0;
      end else begin
        e_ready = '0;
        e_data  = '0;
        if (m_busy != 0) begin
          e_ready[m_grant] = out_ready;
          e_data = req_data[m_grant*DW +: DW];
        end
        check("out_valid", 32'(out_valid), 32'((m_busy != 0) && req_valid[m_grant]));
        check("out_last", 32'(out_last), 32'((m_busy != 0) && (m_rem == 1)));
        check("busy", 32'(busy), 32'(m_busy));
        check("out_id", 32'(out_id), 32'(m_grant));
        check("out_data", 32'(out_data), 32'(e_data));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        if (out_valid && out_ready) begin
          beats_total++;
          beat_cnt++;
          if (dat_on) begin
            if (dat_q.size() == 0) fail("beat_data_extra");
            else check("beat_data", 32'(out_data), 32'(dat_q.pop_front()));
          end
          if (out_last) begin
            bursts_done++;
            if (exp_q.size() == 0) fail("burst_extra");
            else check("burst_id_len", {16'h0, 8'(out_id), 8'(beat_cnt)}, 32'(exp_q.pop_front()));
            beat_cnt = 0;
          end
        end
        if (b_out_valid && b_out_ready) begin
          check("b_out_last", 32'(b_out_last), 32'd1);
          if (b_exp_q.size() == 0) fail("b_grant_extra");
          else check("b_out_id", 32'(b_out_id), 32'(b_exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || b_exp_q.size() != 0 || dat_q.size() != 0); i++)
      tick();
    check("sb_drain", 32'(exp_q.size() + b_exp_q.size() + dat_q.size()), 32'd0);
  endtask

  // mode 4: out_ready toggles on requester 0; mode 5: requester 1 drops valid for 3 cycles
  task automatic drive_burst(input int mode, input int bound);
    automatic int base_beats  = beats_total;
    automatic int base_bursts = bursts_done;
    for (int c = 0; c < bound; c++) begin
      if (mode == 4) begin
        req_valid = 4'b0001;
        out_ready = (c % 2 == 0);
        req_data[7:0] = 8'hA0 + 8'(beats_total - base_beats);
      end else begin
        req_valid = (c >= 3 && c < 6) ? 4'b0100 : 4'b0010;
        out_ready = 1'b1;
        req_data[15:8] = 8'hB0 + 8'(beats_total - base_beats);
      end
      tick();
      if (mode == 5 && c == 3) begin
        check("stall_valid", 32'(out_valid), 32'd0);
        check("stall_id", 32'(out_id), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
      end
      if (bursts_done > base_bursts) break;
    end
    req_valid = '0;
    if (bursts_done == base_bursts) fail("burst_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0; req_len = '0; req_data = '0; out_ready = 1'b0;
    b_req_valid = '0; b_req_len = '0; b_req_data = 24'h332211; b_out_ready = 1'b0;
    #1 rst = 1'b1;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;

    // single requester 2, three beats
    req_data = 32'h44332211;
    req_len[2*LW +: LW] = 4'd3;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    exp_q.push_back({8'd2, 8'd3});
    tick();
    check("t1_first_valid", 32'(out_valid), 32'd1);
    check("t1_id", 32'(out_id), 32'd2);
    check("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    tick();
    check("t1_last", 32'(out_last), 32'd1);
    tick();
    req_valid = '0;
    check("t1_busy_drop", 32'(busy), 32'd0);
    wait_empty(20);

    // contention: all four valid with len 2, from a fresh pointer
    apply_reset();
    req_len = {4'd2, 4'd2, 4'd2, 4'd2};
    exp_q.push_back({8'd0, 8'd2});
    exp_q.push_back({8'd1, 8'd2});
    exp_q.push_back({8'd2, 8'd2});
    exp_q.push_back({8'd3, 8'd2});
    exp_q.push_back({8'd0, 8'd2});
    req_valid = 4'b1111;
    repeat (15) tick();
    req_valid = '0;
    wait_empty(20);

    // clamping: len 0 -> 1 beat, len 15 -> 8 beats
    apply_reset();
    req_len = '0;
    req_len[3*LW +: LW] = 4'd15;
    exp_q.push_back({8'd1, 8'd1});
    req_valid = 4'b0010;
    tick();
    check("t3_len0_last", 32'(out_last), 32'd1);
    tick();
    req_valid = 4'b1000;
    exp_q.push_back({8'd3, 8'd8});
    repeat (9) tick();
    req_valid = '0;
    wait_empty(20);

    // backpressure with toggling out_ready
    req_len[0 +: LW] = 4'd4;
    dat_on = 1'b1;
    for (int i = 0; i < 4; i++) dat_q.push_back(8'hA0 + 8'(i));
    exp_q.push_back({8'd0, 8'd4});
    drive_burst(4, 40);
    wait_empty(20);

    // sticky grant while requester 1 drops valid and requester 2 waits
    req_len[1*LW +: LW] = 4'd5;
    for (int i = 0; i < 5; i++) dat_q.push_back(8'hB0 + 8'(i));
    exp_q.push_back({8'd1, 8'd5});
    drive_burst(5, 40);
    wait_empty(20);
    dat_on = 1'b0;

    // asynchronous reset in the middle of a burst
    out_ready = 1'b1;
    req_len[2*LW +: LW] = 4'd6;
    req_valid = 4'b0100;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_out_id", 32'(out_id), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0010;
    req_len[1*LW +: LW] = 4'd3;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back({8'd1, 8'd3});
    tick();
    check("arst_regrant_id", 32'(out_id), 32'd1);
    repeat (3) tick();
    req_valid = '0;
    wait_empty(20);

    // three requesters, single-beat bursts, non power-of-two wrap
    b_out_ready = 1'b1;
    b_req_len = 3'b000;
    b_exp_q.push_back(2'd0);
    b_exp_q.push_back(2'd1);
    b_exp_q.push_back(2'd2);
    b_exp_q.push_back(2'd0);
    b_req_valid = 3'b111;
    tick();
    check("b_first_last", 32'(b_out_last), 32'd1);
    check("b_first_data", 32'(b_out_data), 32'h11);
    repeat (7) tick();
    b_req_valid = '0;
    tick();
    check("b_busy_idle", 32'(b_busy), 32'd0);
    wait_empty(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
